// File: rtl/continuous_monitoring_system_pkg.sv
// Shared types for the continuous monitoring system control path.
// Holds the control address map, FSM states and response status codes.
package continuous_monitoring_system_pkg;

    localparam int CTRL_ADDR_WIDTH = 8;
    localparam int CTRL_DATA_WIDTH = 32;

    typedef enum logic [CTRL_ADDR_WIDTH-1:0] {
        CTRL_REG0            = 8'd0,
        CTRL_REG1            = 8'd1,
        CTRL_REG2            = 8'd2,
        CTRL_REG3            = 8'd3,
        CTRL_REG4            = 8'd4,
        CTRL_REG5            = 8'd5,
        CTRL_REG6            = 8'd6,
        CTRL_REG7            = 8'd7,
        WFI_STOPPED          = 8'd8,
        CLK_COUNTER          = 8'd9,
        LAST_WRITE_TIMESTAMP = 8'd10
    } ctrl_addr_t;

    // Highest writable address and highest valid address.
    localparam logic [CTRL_ADDR_WIDTH-1:0] CTRL_LAST_RW = 8'd7;
    localparam logic [CTRL_ADDR_WIDTH-1:0] CTRL_LAST_RO = 8'd10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_RD,
`ifdef CMS_CTRL_MASTER_READBACK_VERIFY_EN
        ST_VERIFY,
`endif
        ST_RESP
    } cms_state_t;

    typedef enum logic [1:0] {
        RSP_OK         = 2'b00,
        RSP_BAD_ADDR   = 2'b01,
        RSP_RO_WRITE   = 2'b10,
        RSP_VERIFY_ERR = 2'b11
    } rsp_err_t;

endpackage

// File: rtl/cms_ctrl_master.sv
// Host-to-monitor control master: accepts one request, drives a single
// ctrl_wr/ctrl_rd strobe, waits READ_LATENCY for read data, returns a response.
// Ports: clk, rst (sync, active-high); req_* host request handshake;
// rsp_* response handshake with rdata and 2-bit status; ctrl_* monitor port;
// busy = not idle. Optional macro CMS_CTRL_MASTER_READBACK_VERIFY_EN adds a
// read-back compare after every accepted write (status 11 on mismatch).
module cms_ctrl_master
    import continuous_monitoring_system_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [CTRL_ADDR_WIDTH-1:0] req_addr,
    input  logic [CTRL_DATA_WIDTH-1:0] req_wdata,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [CTRL_DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]                 rsp_error,
    output logic [CTRL_ADDR_WIDTH-1:0] ctrl_addr,
    output logic [CTRL_DATA_WIDTH-1:0] ctrl_wdata,
    output logic                       ctrl_wr,
    output logic                       ctrl_rd,
    input  logic [CTRL_DATA_WIDTH-1:0] ctrl_rdata,
    output logic                       busy
);

    localparam logic [2:0] CNT_LOAD = 3'(READ_LATENCY - 1);

    cms_state_t                 state, state_d;
    logic [2:0]                 cnt, cnt_d;
    logic [CTRL_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [CTRL_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                       wr_q, wr_d;
    logic [CTRL_DATA_WIDTH-1:0] rdata_q, rdata_d;
    rsp_err_t                   err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= RSP_OK;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    wr_d    = req_write;
                    rdata_d = '0;
                    // Rejected requests skip the monitor port entirely.
                    if (req_addr > CTRL_LAST_RO) begin
                        err_d   = RSP_BAD_ADDR;
                        state_d = ST_RESP;
                    end else if (req_write && req_addr > CTRL_LAST_RW) begin
                        err_d   = RSP_RO_WRITE;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = RSP_OK;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = CNT_LOAD;
                if (wr_q) begin
`ifdef CMS_CTRL_MASTER_READBACK_VERIFY_EN
                    state_d = ST_VERIFY;
`else
                    state_d = ST_RESP;
`endif
                end else begin
                    state_d = ST_WAIT_RD;
                end
            end
`ifdef CMS_CTRL_MASTER_READBACK_VERIFY_EN
            ST_VERIFY: begin
                state_d = ST_WAIT_RD;
            end
`endif
            ST_WAIT_RD: begin
                if (cnt == 3'd0) begin
                    state_d = ST_RESP;
`ifdef CMS_CTRL_MASTER_READBACK_VERIFY_EN
                    // A write in WAIT_RD is a read-back: compare, return no data.
                    if (wr_q) begin
                        rdata_d = '0;
                        err_d   = (ctrl_rdata != wdata_q) ? RSP_VERIFY_ERR
                                                          : RSP_OK;
                    end else begin
                        rdata_d = ctrl_rdata;
                    end
`else
                    rdata_d = ctrl_rdata;
`endif
                end else begin
                    cnt_d = cnt - 3'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready  = (state == ST_IDLE);
    assign busy       = (state != ST_IDLE);
    assign rsp_valid  = (state == ST_RESP);
    assign rsp_rdata  = rdata_q;
    assign rsp_error  = err_q;
    assign ctrl_addr  = addr_q;
    assign ctrl_wdata = wdata_q;
    assign ctrl_wr    = (state == ST_ISSUE) && wr_q;
`ifdef CMS_CTRL_MASTER_READBACK_VERIFY_EN
    assign ctrl_rd    = ((state == ST_ISSUE) && !wr_q) || (state == ST_VERIFY);
`else
    assign ctrl_rd    = (state == ST_ISSUE) && !wr_q;
`endif

endmodule

// File: tb/tb_cms_ctrl_master.sv
// Self-checking bench for cms_ctrl_master: directed and random transactions
// checked cycle by cycle against a timing model derived from the address map.
module tb_cms_ctrl_master;
    import continuous_monitoring_system_pkg::*;

    localparam int RL = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_error;
    logic [7:0]  ctrl_addr;
    logic [31:0] ctrl_wdata;
    logic        ctrl_wr;
    logic        ctrl_rd;
    logic [31:0] ctrl_rdata;
    logic        busy;

    int checks = 0;
    int errors = 0;

    cms_ctrl_master #(.READ_LATENCY(RL)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_error (rsp_error),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdata(ctrl_wdata),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_rdata(ctrl_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(string tag);
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, " rsp_rdata"}, rsp_rdata, 32'd0);
        chk({tag, " rsp_error"}, 32'(rsp_error), 32'd0);
        chk({tag, " ctrl_addr"}, 32'(ctrl_addr), 32'd0);
        chk({tag, " ctrl_wdata"}, ctrl_wdata, 32'd0);
        chk({tag, " ctrl_wr"}, 32'(ctrl_wr), 32'd0);
        chk({tag, " ctrl_rd"}, 32'(ctrl_rd), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // One full transaction. Cycle k counts from the acceptance edge (k=1 is T+1).
    // rv is the monitor read value, presented only in the cycle it must be sampled.
    task automatic run_txn(bit wr, logic [7:0] a, logic [31:0] d,
                           logic [31:0] rv, int hold);
        int err, wr_k, rd_k, cap_k, rsp_k;
        logic [31:0] exp_rdata;
        wr_k = 0; rd_k = 0; cap_k = 0; exp_rdata = 32'd0;
        if (a > 8'd10) begin
            err = 1; rsp_k = 1;
        end else if (wr && a > 8'd7) begin
            err = 2; rsp_k = 1;
        end else if (wr) begin
            err = 0; wr_k = 1;
`ifdef CMS_CTRL_MASTER_READBACK_VERIFY_EN
            rd_k = 2; cap_k = 2 + RL; rsp_k = 3 + RL;
            if (rv != d) err = 3;
`else
            rsp_k = 2;
`endif
        end else begin
            err = 0; rd_k = 1; cap_k = 1 + RL; rsp_k = 2 + RL;
            exp_rdata = rv;
        end

        @(negedge clk);
        chk("idle req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = a;
        req_wdata = d;
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = $urandom_range(0, 1);
        req_addr  = 8'($urandom);
        req_wdata = $urandom;
        for (int k = 1; k <= rsp_k + hold; k++) begin
            if (k > 1) @(negedge clk);
            ctrl_rdata = (k == cap_k) ? rv : $urandom;
            chk("ctrl_wr", 32'(ctrl_wr), 32'(k == wr_k));
            chk("ctrl_rd", 32'(ctrl_rd), 32'(k == rd_k));
            chk("rsp_valid", 32'(rsp_valid), 32'(k >= rsp_k));
            chk("busy", 32'(busy), 32'd1);
            chk("req_ready busy", 32'(req_ready), 32'd0);
            chk("ctrl_addr", 32'(ctrl_addr), 32'(a));
            chk("ctrl_wdata", ctrl_wdata, d);
            if (k >= rsp_k) begin
                chk("rsp_rdata", rsp_rdata, exp_rdata);
                chk("rsp_error", 32'(rsp_error), 32'(err));
            end
            if (k == rsp_k + hold) rsp_ready = 1'b1;
        end
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("post rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post busy", 32'(busy), 32'd0);
        chk("post req_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        logic [7:0]  a;
        logic [31:0] d;
        logic [31:0] rv;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = 8'd0;
        req_wdata  = 32'd0;
        rsp_ready  = 1'b0;
        ctrl_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        // Directed: write, read with latency, rejected requests, long stall.
        run_txn(1'b1, 8'd2, 32'h8000_0000, 32'h8000_0000, 0);
        run_txn(1'b0, 8'd9, 32'h0, 32'h0000_1234, 0);
        run_txn(1'b1, 8'd9, 32'hdead_beef, 32'h0, 0);
        run_txn(1'b0, 8'h20, 32'h0, 32'h5555_aaaa, 0);
        run_txn(1'b1, 8'd6, 32'h100, 32'h0ff, 0);
        run_txn(1'b0, 8'd10, 32'h0, 32'hcafe_f00d, 10);
        run_txn(1'b1, 8'd7, 32'h1234_5678, 32'h1234_5678, 10);
        run_txn(1'b0, 8'd11, 32'h0, 32'h1, 2);

        // Reset in the middle of WAIT_RD.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 8'd3;
        req_wdata = 32'h0bad_0bad;
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort ctrl_rd", 32'(ctrl_rd), 32'd1);
        @(negedge clk);
        chk("abort busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset_outputs("abort");
        @(negedge clk);
        chk_reset_outputs("abort+1");

        // Random traffic across all address classes.
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: a = 8'($urandom_range(0, 7));
                1: a = 8'($urandom_range(8, 10));
                2: a = 8'($urandom_range(11, 255));
                default: a = 8'h20;
            endcase
            d  = $urandom;
            rv = $urandom_range(0, 1) ? d : $urandom;
            run_txn(1'($urandom_range(0, 1)), a, d, rv, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
